// File: rtl/instr_pkg.sv
// Shared types and constants for RV32I instruction packing. Shared with the decoder-side benches.
package instr_pkg;

  typedef enum logic [1:0] {
    FMT_R  = 2'd0,
    FMT_I  = 2'd1,
    FMT_S  = 2'd2,
    FMT_SB = 2'd3
  } fmt_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Representable immediates: 12-bit signed for I/S, 13-bit even for SB.
  localparam int IMM12_MIN = -2048;
  localparam int IMM12_MAX = 2047;
  localparam int IMM13_MIN = -4096;
  localparam int IMM13_MAX = 4094;

endpackage

// File: rtl/instr_pack_comb.sv
// Combinational RV32I field packing; the immediate range check exists only when
// IMM_RANGE_CHECK_EN is defined, otherwise immediates are truncated and err is 0.
module instr_pack_comb
  import instr_pkg::*;
(
  input  fmt_e        fmt,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic [31:0] instr,
  output logic        err
);

  logic [31:0] raw_instr;

  always_comb begin
    raw_instr = 32'h0;
    case (fmt)
      FMT_R:  raw_instr = {funct7, rs2, rs1, funct3, rd, opcode};
      FMT_I:  raw_instr = {imm[11:0], rs1, funct3, rd, opcode};
      FMT_S:  raw_instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      FMT_SB: raw_instr = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      default: raw_instr = 32'h0;
    endcase
  end

`ifdef IMM_RANGE_CHECK_EN
  logic bad_imm;

  always_comb begin
    bad_imm = 1'b0;
    case (fmt)
      FMT_I, FMT_S:
        bad_imm = ($signed(imm) < IMM12_MIN) || ($signed(imm) > IMM12_MAX);
      FMT_SB:
        bad_imm = ($signed(imm) < IMM13_MIN) || ($signed(imm) > IMM13_MAX) || imm[0];
      default:
        bad_imm = 1'b0;
    endcase
  end

  assign instr = bad_imm ? NOP_INSTR : raw_instr;
  assign err   = bad_imm;
`else
  // Upper immediate bits are deliberately dropped in the truncating build.
  logic unused_imm_bits;
  assign unused_imm_bits = ^{imm[31:13], imm[0]};
  assign instr = raw_instr;
  assign err   = 1'b0;
`endif

endmodule

// File: rtl/instr_packer.sv
// Packs decoded fields into RV32I words and streams DEPTH addressed words per start pulse
// through a one-deep registered output stage. Range checking enabled by IMM_RANGE_CHECK_EN.
module instr_packer
  import instr_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          DEPTH     = 64,
  parameter int          CNT_W     = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_fmt,
  input  logic [6:0]  in_opcode,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic        out_last,
  output logic        out_err,
  output logic        busy,
  output logic        done
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(DEPTH - 1);

  state_e           state_reg;
  logic [CNT_W-1:0] acc_cnt_reg;
  logic             out_valid_reg;
  logic [31:0]      out_instr_reg;
  logic [31:0]      out_addr_reg;
  logic             out_last_reg;
  logic             out_err_reg;

  logic [31:0] packed_instr;
  logic        packed_err;
  logic        accept;
  logic        out_hs;

  instr_pack_comb u_pack (
    .fmt    (fmt_e'(in_fmt)),
    .opcode (in_opcode),
    .rd     (in_rd),
    .rs1    (in_rs1),
    .rs2    (in_rs2),
    .funct3 (in_funct3),
    .funct7 (in_funct7),
    .imm    (in_imm),
    .instr  (packed_instr),
    .err    (packed_err)
  );

  assign in_ready = (state_reg == RUN) && (acc_cnt_reg < DEPTH_C) &&
                    (!out_valid_reg || out_ready);
  assign accept   = in_valid && in_ready;
  assign out_hs   = out_valid_reg && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      acc_cnt_reg   <= '0;
      out_valid_reg <= 1'b0;
      out_instr_reg <= 32'h0;
      out_addr_reg  <= BASE_ADDR;
      out_last_reg  <= 1'b0;
      out_err_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (start) begin
            state_reg     <= RUN;
            acc_cnt_reg   <= '0;
            out_addr_reg  <= BASE_ADDR;
            out_valid_reg <= 1'b0;
          end
        end
        RUN: begin
          // Address tracks the word in the register: it steps only when a word leaves.
          if (out_hs) begin
            out_addr_reg <= out_addr_reg + 32'd4;
            if (!accept)
              out_valid_reg <= 1'b0;
            if (out_last_reg)
              state_reg <= DONE;
          end
          if (accept) begin
            out_valid_reg <= 1'b1;
            out_instr_reg <= packed_instr;
            out_err_reg   <= packed_err;
            out_last_reg  <= (acc_cnt_reg == LAST_C);
            acc_cnt_reg   <= acc_cnt_reg + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_reg;
  assign out_instr = out_instr_reg;
  assign out_addr  = out_addr_reg;
  assign out_last  = out_last_reg;
  assign out_err   = out_err_reg;
  assign busy      = (state_reg == RUN);
  assign done      = (state_reg == DONE);

endmodule

// File: tb/tb_instr_packer.sv
// Directed self-checking bench for instr_packer with DEPTH=4; expected words are hand-encoded.
module tb_instr_packer;

  logic        clk = 1'b0;
  logic        rst, start, in_valid, in_ready;
  logic [1:0]  in_fmt;
  logic [6:0]  in_opcode, in_funct7;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [2:0]  in_funct3;
  logic [31:0] in_imm;
  logic        out_valid, out_ready, out_last, out_err, busy, done;
  logic [31:0] out_instr, out_addr;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  instr_packer #(.BASE_ADDR(32'h0), .DEPTH(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1),
    .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_addr(out_addr), .out_last(out_last), .out_err(out_err),
    .busy(busy), .done(done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fields(input logic [1:0] f, input logic [6:0] op, input logic [4:0] rd,
                            input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                            input logic [6:0] f7, input logic [31:0] imm);
    in_fmt = f; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm;
  endtask

  logic [31:0] exp_range_instr;
  logic [31:0] exp_range_err;

  initial begin
`ifdef IMM_RANGE_CHECK_EN
    exp_range_instr = 32'h0000_0013;
    exp_range_err   = 32'd1;
`else
    exp_range_instr = 32'h8000_0093;
    exp_range_err   = 32'd0;
`endif
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    set_fields(2'd0, 7'h0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0);
    step(); step();
    rst = 1'b0;
    step();
    check("rst_in_ready",  32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy",      32'(busy), 32'd0);
    check("rst_done",      32'(done), 32'd0);
    check("rst_out_addr",  out_addr, 32'h0);
    check("rst_out_instr", out_instr, 32'h0);
    check("rst_out_err",   32'(out_err), 32'd0);

    // Burst 1: addi, out-of-range addi under backpressure, add, addi x5,x5,-1.
    start = 1'b1; step(); start = 1'b0;
    check("run_busy",     32'(busy), 32'd1);
    check("run_in_ready", 32'(in_ready), 32'd1);

    set_fields(2'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    in_valid = 1'b1;
    step();
    check("addi_valid", 32'(out_valid), 32'd1);
    check("addi_instr", out_instr, 32'h0050_0093);
    check("addi_addr",  out_addr, 32'h0);
    check("addi_last",  32'(out_last), 32'd0);

    set_fields(2'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_instr",    out_instr, 32'h0050_0093);
      check("bp_addr",     out_addr, 32'h0);
      check("bp_valid",    32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", 32'(in_ready), 32'd1);
    step();
    check("range_instr", out_instr, exp_range_instr);
    check("range_err",   32'(out_err), exp_range_err);
    check("range_addr",  out_addr, 32'h4);

    set_fields(2'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFFF);
    step();
    check("add_instr", out_instr, 32'h0020_81B3);
    check("add_addr",  out_addr, 32'h8);
    check("add_err",   32'(out_err), 32'd0);

    set_fields(2'd1, 7'h13, 5'd5, 5'd5, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF);
    step();
    in_valid = 1'b0;
    check("last_instr",    out_instr, 32'hFFF2_8293);
    check("last_addr",     out_addr, 32'hC);
    check("last_flag",     32'(out_last), 32'd1);
    check("last_done",     32'(done), 32'd0);
    check("last_in_ready", 32'(in_ready), 32'd0);

    step();
    check("done_flag",     32'(done), 32'd1);
    check("done_busy",     32'(busy), 32'd0);
    check("done_valid",    32'(out_valid), 32'd0);
    check("done_in_ready", 32'(in_ready), 32'd0);
    step();
    check("done_hold", 32'(done), 32'd1);

    // Burst 2: restart from BASE_ADDR with sw then beq, then reset mid-burst.
    start = 1'b1; step(); start = 1'b0;
    check("restart_busy", 32'(busy), 32'd1);
    check("restart_addr", out_addr, 32'h0);

    set_fields(2'd2, 7'h23, 5'd0, 5'd3, 5'd2, 3'd2, 7'd0, 32'hFFFF_FFFC);
    in_valid = 1'b1;
    step();
    check("sw_instr", out_instr, 32'hFE21_AE23);
    check("sw_addr",  out_addr, 32'h0);

    set_fields(2'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFF8);
    step();
    check("beq_instr", out_instr, 32'hFE20_8CE3);
    check("beq_addr",  out_addr, 32'h4);
    check("beq_last",  32'(out_last), 32'd0);

    in_valid = 1'b0; out_ready = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_valid",    32'(out_valid), 32'd0);
    check("midrst_busy",     32'(busy), 32'd0);
    check("midrst_done",     32'(done), 32'd0);
    check("midrst_addr",     out_addr, 32'h0);
    check("midrst_instr",    out_instr, 32'h0);
    check("midrst_in_ready", 32'(in_ready), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_packer.md
Name: instr_packer

Overview:
- Encoder counterpart of the immediate generator. Packs decoded instruction fields (format, opcode, registers, funct, signed immediate) into a 32-bit RV32I word.
- Emits the packed words sequentially, with byte addresses, for the instruction-memory loader and for self-check benches.
- Uses a one-deep registered output stage with valid/ready handshakes on both sides.
- Runs a burst of DEPTH words per start pulse.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of the first emitted word.
- DEPTH, 64, number of words per burst; must be at least 1.
- CNT_W, 16, width of the word counter; requires DEPTH < 2**CNT_W.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse; begins a burst.
- in_valid  in  1  input fields valid.
- in_ready  out  1  block accepts fields this cycle.
- in_fmt  in  2  format select: 0=R, 1=I, 2=S, 3=SB.
- in_opcode  in  7  opcode field.
- in_rd  in  5  rd field.
- in_rs1  in  5  rs1 field.
- in_rs2  in  5  rs2 field.
- in_funct3  in  3  funct3 field.
- in_funct7  in  7  funct7 field; used by R format only.
- in_imm  in  32  signed immediate; ignored for R format.
- out_valid  out  1  packed word valid.
- out_ready  in  1  consumer accepts the word.
- out_instr  out  32  packed instruction.
- out_addr  out  32  byte address of out_instr.
- out_last  out  1  out_instr is the final word of the burst.
- out_err  out  1  immediate was out of range (feature-dependent).
- busy  out  1  state is RUN.
- done  out  1  state is DONE.

Behaviour:
- Reset values:
  - state = IDLE.
  - in_ready, out_valid, out_last, out_err, busy, done = 0.
  - out_instr = 0; out_addr = BASE_ADDR; word count = 0.
- FSM state IDLE:
  - start moves to RUN and clears the count.
  - in_ready = 0.
- FSM state RUN:
  - in_ready = (acc_cnt < DEPTH) and (!out_valid or out_ready). acc_cnt counts accepted inputs.
  - Moves to DONE on the output handshake of the word with out_last = 1.
- FSM state DONE:
  - done = 1.
  - start returns to RUN with the count cleared and out_addr = BASE_ADDR.
  - Otherwise holds.
- start while in RUN is ignored.
- Accept: in_valid && in_ready in cycle N. out_valid = 1 from cycle N+1 with the packed word. Latency is 1 cycle.
- Throughput is 1 word per cycle while out_ready = 1.
- Output hold: while out_valid && !out_ready, out_instr, out_addr, out_last and out_err hold stable, and in_ready = 0.
- Simultaneous output handshake and new input accept in the same cycle: the register reloads with the new word; out_valid stays 1.
- Address: out_addr of the k-th word = BASE_ADDR + 4*k, k counted from 0. It advances only on an output handshake. 32-bit wrap-around is permitted and not flagged.
- out_last = 1 for the word with k = DEPTH-1.
- Packing (bit positions):
  - R: {funct7, rs2, rs1, funct3, rd, opcode}.
  - I: {imm[11:0], rs1, funct3, rd, opcode}.
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
  - SB: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}; imm[0] is dropped.
- Round-trip requirement: feeding out_instr to the immediate generator must return in_imm for every in-range value.
- Reset mid-burst: all state returns to reset values; the pending word is discarded.

Optional Feature:
- Macro: IMM_RANGE_CHECK_EN.
- Defined, valid ranges:
  - I and S: -2048..2047.
  - SB: -4096..4094, and the value must be even.
- Defined, out-of-range handling: the word is emitted as NOP 32'h0000_0013 with out_err = 1. The address still advances.
- Undefined: immediates are silently truncated to the field bits, and out_err is tied to 0.

Decomposition:
- Package instr_pkg holds:
  - The fmt_e enum (FMT_R, FMT_I, FMT_S, FMT_SB).
  - The state_e enum (IDLE, RUN, DONE).
  - NOP_INSTR = 32'h0000_0013.
  - The immediate range constants.
- The package is shared with the decoder-side benches.
- One sub-module, instr_pack_comb: purely combinational field packing plus the range check. The top level holds the FSM, counter and output register.

Test Plan:
- Reset and idle: hold rst for 2 cycles, then drop it with no start → in_ready = 0, out_valid = 0, busy = 0, done = 0, out_addr = 0.
- I-type: start, then addi x1,x0,5 (fmt=1, op=0x13, rd=1, f3=0, imm=5) → out_instr = 0x00500093 and out_addr = 0, one cycle after accept.
- S-type, then SB-type:
  - sw x2,-4(x3) (op=0x23, f3=2, rs1=3, rs2=2, imm=-4) → 0xFE21AE23.
  - Next, beq x1,x2,-8 (op=0x63, f3=0, rs1=1, rs2=2, imm=-8) → 0xFE208CE3 at out_addr = 4.
- Backpressure: out_ready = 0 for 3 cycles with in_valid held high → word and address stable, in_ready = 0, no words lost or duplicated.
- Burst end, DEPTH=4: 4 words accepted → out_last = 1 on the word at 0xC, done = 1 after its handshake, in_ready = 0. A new start restarts at 0x0. rst asserted mid-burst returns everything to reset values.
- Range check: addi with imm = 2048 → with IMM_RANGE_CHECK_EN, out_instr = 0x00000013 and out_err = 1; without it, out_instr = 0x80000093 and out_err = 0.
